// File: rtl/muxn_pipe.sv
`default_nettype none
// muxn_pipe: N-channel registered mux, explicit-select or round-robin, with a one-entry output register.
// Optional out_chan port/register enabled by defining MUXN_PIPE_CHAN_EN.  Rev 1.0
module muxn_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sel_err
`ifdef MUXN_PIPE_CHAN_EN
  ,
  output logic [SELW-1:0]      out_chan
`endif
);

  localparam logic [SELW:0] N_W = (SELW+1)'(N);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic             load;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [SELW:0]    cand;
  logic [WIDTH-1:0] grant_data;
  logic             grant_valid_in;
  logic             xfer;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!mode) begin
      grant_vld = ({1'b0, sel} < N_W);
      grant_idx = sel;
    end else begin
      // Descending scan so the lowest offset from rr_ptr+1 wins.
      for (int k = N; k >= 1; k--) begin
        cand = {1'b0, rr_ptr_q} + (SELW+1)'(k);
        if (cand >= N_W) cand = cand - N_W;
        for (int i = 0; i < N; i++) begin
          if (cand[SELW-1:0] == SELW'(i) && in_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = SELW'(i);
          end
        end
      end
    end
  end

  always_comb begin
    load           = !out_valid_q || out_ready;
    grant_data     = '0;
    grant_valid_in = 1'b0;
    in_ready       = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data     = in_data[i*WIDTH +: WIDTH];
        grant_valid_in = in_valid[i];
        in_ready[i]    = grant_vld && load;
      end
    end
    xfer = load && grant_vld && grant_valid_in;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    sel_err_d   = !mode && ({1'b0, sel} >= N_W);
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = grant_data;
        if (mode) rr_ptr_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      rr_ptr_q    <= SELW'(N-1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

`ifdef MUXN_PIPE_CHAN_EN
  logic [SELW-1:0] out_chan_q, out_chan_d;

  always_comb begin
    out_chan_d = out_chan_q;
    if (xfer) out_chan_d = grant_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_chan_q <= '0;
    else        out_chan_q <= out_chan_d;
  end

  assign out_chan = out_chan_q;
`endif

endmodule
`default_nettype wire

// File: doc/muxn_pipe.md
# muxn_pipe

Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes and a one-entry output register. It has two modes: explicit select, or round-robin arbitration across valid channels. It succeeds the fixed 3-to-1 32-bit mux in the ALU datapath, adding backpressure, invalid-select reporting and fair sharing of one downstream consumer among several producers.

## Interface
- `WIDTH`, 32, data width per channel
- `N`, 3, number of input channels (2..16)
- `SELW`, `$clog2(N)` (min 1), select/channel-index width

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- `in_valid`  in  N  per-channel valid
- `in_ready`  out  N  per-channel ready; combinational
- `mode`  in  1  0 = explicit select via `sel`, 1 = round-robin
- `sel`  in  SELW  channel index when mode=0
- `out_data`  out  WIDTH  registered output data
- `out_valid`  out  1  registered output valid
- `out_ready`  in  1  downstream ready
- `sel_err`  out  1  registered; high for one cycle per invalid-select cycle
- `out_chan`  out  SELW  source channel of `out_data`; present only with `MUXN_PIPE_CHAN_EN`

## Operation
- **load** = `!out_valid || out_ready`. The output register accepts a beat when load=1 and a channel is granted with `in_valid` high.
- **grant (mode=0):** channel `sel` if `sel < N`, otherwise no grant.
- **grant (mode=1):** first i with `in_valid[i]=1`, searching from `rr_ptr+1` upward and wrapping modulo N. No grant when no channel is valid.
- **in_ready[i]** = grant[i] && load. Only one bit is high at a time. `in_ready` does not depend on `in_valid` in mode 0. In mode 1 it does, because grant depends on valid.
- **Transfer on channel i:**
  - `out_data` ← channel i data; `out_valid` ← 1; `out_chan` ← i.
  - In mode 1 only, `rr_ptr` ← i.
- **load=1 with no transfer:** `out_valid` ← 0 (the held beat was consumed).
- **load=0:** `out_data`, `out_valid` and `out_chan` hold. No channel is ready.
- **sel_err** ← (mode==0 && sel ≥ N), registered every cycle, independent of valid/ready. It is never set in mode 1.
- `rr_ptr` is retained across mode switches. Mode 0 transfers do not move it.
- **Reset (asserted at any time, including mid-transfer):**
  - `out_valid`=0, `out_data`=0, `out_chan`=0, `sel_err`=0.
  - `rr_ptr`=N-1, so the first round-robin grant goes to channel 0.
  - The in-flight beat is discarded.

## Timing
- Latency is 1 cycle: a beat accepted at edge k appears on `out_data`/`out_valid` after edge k.
- Throughput is one beat per cycle while `out_ready`=1.
- The combinational path `out_ready`/`mode`/`sel`/`in_valid` → `in_ready` is permitted. There is no path from any input to `out_*`.
- `mode` and `sel` changes take effect in the same cycle. The beat already in the output register keeps its original channel.
- Simultaneous drain and refill (`out_valid`=1, `out_ready`=1, granted valid) is a back-to-back transfer with no bubble.
- When all N channels are valid in mode 1, grants rotate 0,1,…,N-1,0 with one grant per transfer.
- Under stall (`out_ready`=0, `out_valid`=1), `rr_ptr` does not advance.

## Configuration
- `MUXN_PIPE_CHAN_EN` defined: the `out_chan` port and its register exist, with reset value 0. It updates only on transfer.
- Not defined: the `out_chan` port and its register are absent. All other behaviour is identical.

## Test plan
- **Explicit select:** N=3, WIDTH=32, data 0x1/0x2/0x3, all valid, `out_ready`=1, mode=0, sel 0→1→2→1, one step per cycle. Required: `out_data` 0x1,0x2,0x3,0x2 one cycle later each, `out_valid`=1, and `in_ready` one-hot matching sel.
- **Invalid select:** mode=0, sel=3 for 2 cycles. Required: `in_ready`=000, `out_valid` falls to 0 after one cycle, `sel_err`=1 for exactly 2 cycles, then 0 after sel returns to 0.
- **Round-robin fairness:** mode=1, all valid, `out_ready`=1, 6 cycles after reset. Required: `out_data` sequence 0x1,0x2,0x3,0x1,0x2,0x3, and with the macro defined `out_chan` reads 0,1,2,0,1,2.
- **Sparse round-robin:** mode=1, only channels 0 and 2 valid. Required: alternating 0x1,0x3. Channel 1 is never granted and `in_ready[1]` stays 0.
- **Backpressure:** fill the output with 0x2, then hold `out_ready`=0 for 3 cycles with all valid. Required: `out_data`=0x2 held, `in_ready`=000, `rr_ptr` unchanged. On `out_ready`=1 the next grant goes to channel 2 with no bubble.
- **Reset mid-operation:** assert `rst_n`=0 asynchronously while `out_valid`=1. Required: `out_valid`/`out_data`/`sel_err` go to 0 immediately. After release in mode 1, the first grant is channel 0.
